// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive/transmit blocks.
`timescale 1ns/1ps
package uart_pkg;

   localparam int unsigned DATA_BITS = 8;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      START = 3'd1,
      DATA  = 3'd2,
      STOP  = 3'd3,
      BREAK = 3'd4
   } rx_state_t;

   // Clock cycles per oversample tick, truncated.
   function automatic int unsigned calc_div(input int unsigned clk_freq,
                                            input int unsigned baud,
                                            input int unsigned oversample);
      return clk_freq / (baud * oversample);
   endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running oversample tick divider with a synchronous phase-align clear.
`timescale 1ns/1ps
module uart_baud_tick #(
   parameter int unsigned DIV = 54
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_clr,
   output logic o_tick_c
);

   localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;

   logic [CW-1:0] r_cnt;
   logic          w_wrap;

   assign w_wrap   = (r_cnt == CW'(DIV - 1));
   assign o_tick_c = w_wrap;

   // Count 0..DIV-1, restart on wrap or on clear.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cnt <= '0;
      end else if (i_clr || w_wrap) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + CW'(1);
      end
   end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 16x oversampling, mid-bit sampling, one-byte holding buffer.
`timescale 1ns/1ps
module uart_rx
   import uart_pkg::*;
#(
   parameter int unsigned CLK_FREQ   = 100000000,
   parameter int unsigned BAUD       = 115200,
   parameter int unsigned OVERSAMPLE = 16
) (
   input  logic       CLK100MHZ,
   input  logic       CPU_RESETN,
   input  logic       uart_rxd,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic       rx_ready,
   output logic       frame_err,
   output logic       overrun,
   output logic       rx_busy
);

   localparam int unsigned DIV = calc_div(CLK_FREQ, BAUD, OVERSAMPLE);
   localparam int unsigned SCW = $clog2(OVERSAMPLE);
   localparam int unsigned BIW = $clog2(DATA_BITS);
   localparam logic [SCW-1:0] SC_HALF = SCW'(OVERSAMPLE / 2 - 1);
   localparam logic [SCW-1:0] SC_LAST = SCW'(OVERSAMPLE - 1);
   localparam logic [BIW-1:0] BI_LAST = BIW'(DATA_BITS - 1);

   rx_state_t             r_state;
   rx_state_t             w_state_nxt;
   logic                  r_sync1;
   logic                  r_sync2;
   logic                  w_rxd_s;
   logic                  w_tick;
   logic [SCW-1:0]        r_sc;
   logic [BIW-1:0]        r_bit_idx;
   logic [DATA_BITS-1:0]  r_shift;
   logic [DATA_BITS-1:0]  r_data;
   logic                  r_valid;
   logic                  r_done;
   logic                  r_fe;
   logic                  r_ovr;
   logic                  r_busy;
   logic                  w_drain;

   logic                  w_div_clr;
   logic                  w_sc_clr;
   logic                  w_sc_inc;
   logic                  w_bit_clr;
   logic                  w_shift_en;
   logic                  w_done;
   logic                  w_fe;

   assign w_rxd_s   = r_sync2;
   assign w_drain   = r_valid & rx_ready;
   assign rx_data   = r_data;
   assign rx_valid  = r_valid;
   assign frame_err = r_fe;
   assign overrun   = r_ovr;
   assign rx_busy   = r_busy;

   uart_baud_tick #(.DIV(DIV)) u_tick (
      .i_clk    (CLK100MHZ),
      .i_rst_n  (CPU_RESETN),
      .i_clr    (w_div_clr),
      .o_tick_c (w_tick)
   );

   // Two-flop synchroniser for the asynchronous serial line (idles high).
   always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
      if (!CPU_RESETN) begin
         r_sync1 <= 1'b1;
         r_sync2 <= 1'b1;
      end else begin
         r_sync1 <= uart_rxd;
         r_sync2 <= r_sync1;
      end
   end

   // FSM state register.
   always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
      if (!CPU_RESETN) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic; returns to IDLE at mid stop bit so back-to-back frames work.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (!w_rxd_s) w_state_nxt = START;
         START:   if (w_tick && (r_sc == SC_HALF))
                     w_state_nxt = w_rxd_s ? IDLE : DATA;
         DATA:    if (w_tick && (r_sc == SC_LAST) && (r_bit_idx == BI_LAST))
                     w_state_nxt = STOP;
         STOP:    if (w_tick && (r_sc == SC_LAST))
                     w_state_nxt = w_rxd_s ? IDLE : BREAK;
         BREAK:   if (w_rxd_s) w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   // Datapath controls decoded from state, tick and sampled line.
   always_comb begin
      w_div_clr  = 1'b0;
      w_sc_clr   = 1'b0;
      w_sc_inc   = 1'b0;
      w_bit_clr  = 1'b0;
      w_shift_en = 1'b0;
      w_done     = 1'b0;
      w_fe       = 1'b0;
      case (r_state)
         IDLE: begin
            if (!w_rxd_s) begin
               w_div_clr = 1'b1;
               w_sc_clr  = 1'b1;
            end
         end
         START: begin
            if (w_tick) begin
               if (r_sc == SC_HALF) begin
                  w_sc_clr  = 1'b1;
                  w_bit_clr = 1'b1;
               end else begin
                  w_sc_inc = 1'b1;
               end
            end
         end
         DATA: begin
            if (w_tick) begin
               if (r_sc == SC_LAST) begin
                  w_sc_clr   = 1'b1;
                  w_shift_en = 1'b1;
               end else begin
                  w_sc_inc = 1'b1;
               end
            end
         end
         STOP: begin
            if (w_tick) begin
               if (r_sc == SC_LAST) begin
                  w_sc_clr = 1'b1;
                  w_done   = w_rxd_s;
                  w_fe     = ~w_rxd_s;
               end else begin
                  w_sc_inc = 1'b1;
               end
            end
         end
         default: ;
      endcase
   end

   // Tick counter, bit index, shift register and status pulses.
   always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
      if (!CPU_RESETN) begin
         r_sc      <= '0;
         r_bit_idx <= '0;
         r_shift   <= '0;
         r_done    <= 1'b0;
         r_fe      <= 1'b0;
         r_busy    <= 1'b0;
      end else begin
         if (w_sc_clr) begin
            r_sc <= '0;
         end else if (w_sc_inc) begin
            r_sc <= r_sc + SCW'(1);
         end
         if (w_bit_clr) begin
            r_bit_idx <= '0;
         end else if (w_shift_en) begin
            r_bit_idx <= r_bit_idx + BIW'(1);
         end
         if (w_shift_en) begin
            r_shift <= {w_rxd_s, r_shift[DATA_BITS-1:1]};
         end
         r_done <= w_done;
         r_fe   <= w_fe;
         r_busy <= (w_state_nxt != IDLE);
      end
   end

   // Holding buffer: load when empty or draining, otherwise drop and flag overrun.
   always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
      if (!CPU_RESETN) begin
         r_data  <= '0;
         r_valid <= 1'b0;
         r_ovr   <= 1'b0;
      end else begin
         if (r_done && (!r_valid || w_drain)) begin
            r_data  <= r_shift;
            r_valid <= 1'b1;
         end else if (w_drain) begin
            r_valid <= 1'b0;
         end
         r_ovr <= r_done && r_valid && !rx_ready;
      end
   end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx at 100 MHz / 115200 baud (864 clocks per bit).
`timescale 1ns/1ps
module tb_uart_rx;

   localparam int BIT = 864;

   logic       CLK100MHZ;
   logic       CPU_RESETN;
   logic       uart_rxd;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_ready;
   logic       frame_err;
   logic       overrun;
   logic       rx_busy;

   int n_checks = 0;
   int n_errors = 0;
   int n_valid_cyc = 0;
   int n_fe = 0;
   int n_ovr = 0;
   logic [7:0] exp_q[$];

   uart_rx dut (
      .CLK100MHZ  (CLK100MHZ),
      .CPU_RESETN (CPU_RESETN),
      .uart_rxd   (uart_rxd),
      .rx_data    (rx_data),
      .rx_valid   (rx_valid),
      .rx_ready   (rx_ready),
      .frame_err  (frame_err),
      .overrun    (overrun),
      .rx_busy    (rx_busy)
   );

   initial CLK100MHZ = 1'b0;
   always #5 CLK100MHZ = ~CLK100MHZ;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic check_range(input string name, input int act, input int lo, input int hi);
      n_checks++;
      if (act < lo || act > hi) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
      end
   endtask

   task automatic drive_bit(input logic v, input int n);
      uart_rxd = v;
      repeat (n) @(posedge CLK100MHZ);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop_v, input int stop_len);
      @(posedge CLK100MHZ);
      #1;
      drive_bit(1'b0, BIT);
      for (int i = 0; i < 8; i++) drive_bit(b[i], BIT);
      drive_bit(stop_v, stop_len);
   endtask

   // Monitor: pops the scoreboard on every accepted byte and counts status pulses.
   always @(negedge CLK100MHZ) begin
      if (CPU_RESETN) begin
         if (rx_valid) n_valid_cyc++;
         if (frame_err) n_fe++;
         if (overrun) n_ovr++;
         if (rx_valid && rx_ready) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_errors++;
               $display("FAIL unexpected_byte: got 0x%02h, no byte expected", rx_data);
            end else begin
               check("rx_data", {24'd0, rx_data}, {24'd0, exp_q.pop_front()});
            end
         end
      end
   end

   // Watchdog so the run always ends.
   initial begin
      #(1_000_000);
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      int busy_cnt;
      int v0, fe0, ov0;

      CPU_RESETN = 1'b0;
      uart_rxd   = 1'b1;
      rx_ready   = 1'b0;
      repeat (5) @(posedge CLK100MHZ);
      #1;
      check("reset_rx_valid",  {31'd0, rx_valid},  32'd0);
      check("reset_rx_data",   {24'd0, rx_data},   32'd0);
      check("reset_frame_err", {31'd0, frame_err}, 32'd0);
      check("reset_overrun",   {31'd0, overrun},   32'd0);
      check("reset_rx_busy",   {31'd0, rx_busy},   32'd0);
      CPU_RESETN = 1'b1;
      repeat (20) @(posedge CLK100MHZ);
      #1;

      // Single byte; completion at mid stop (9.5 bits = 8208) plus sync/register latency.
      rx_ready = 1'b1;
      exp_q.push_back(8'hA5);
      v0 = n_valid_cyc; fe0 = n_fe; ov0 = n_ovr;
      lat = 0;
      fork
         send_byte(8'hA5, 1'b1, BIT);
         begin
            @(negedge uart_rxd);
            while (!rx_valid && lat < 9000) begin
               @(posedge CLK100MHZ);
               #1;
               lat++;
            end
         end
      join
      repeat (20) @(posedge CLK100MHZ);
      #1;
      check_range("single_latency", lat, 8205, 8220);
      check("single_valid_cycles", n_valid_cyc - v0, 1);
      check("single_frame_err", n_fe - fe0, 0);
      check("single_overrun", n_ovr - ov0, 0);

      // Glitch: 200-clock low pulse is rejected at the half-bit (432 clock) check.
      v0 = n_valid_cyc; fe0 = n_fe;
      busy_cnt = 0;
      uart_rxd = 1'b0;
      fork
         begin
            repeat (200) @(posedge CLK100MHZ);
            #1;
            uart_rxd = 1'b1;
         end
         begin
            repeat (1000) begin
               @(posedge CLK100MHZ);
               #1;
               if (rx_busy) busy_cnt++;
            end
         end
      join
      check_range("glitch_busy_cycles", busy_cnt, 428, 436);
      check("glitch_busy_end", {31'd0, rx_busy}, 32'd0);
      check("glitch_no_valid", n_valid_cyc - v0, 0);
      check("glitch_no_frame_err", n_fe - fe0, 0);

      // Framing error followed by break held for 3 bit times.
      v0 = n_valid_cyc; fe0 = n_fe;
      send_byte(8'h3C, 1'b0, 3 * BIT);
      check("break_busy_held", {31'd0, rx_busy}, 32'd1);
      check("frame_err_pulses", n_fe - fe0, 1);
      uart_rxd = 1'b1;
      repeat (5) @(posedge CLK100MHZ);
      #1;
      check("break_busy_released", {31'd0, rx_busy}, 32'd0);
      check("frame_no_valid", n_valid_cyc - v0, 0);
      exp_q.push_back(8'h55);
      send_byte(8'h55, 1'b1, BIT);
      repeat (20) @(posedge CLK100MHZ);
      #1;

      // Overrun: second back-to-back byte dropped while buffer is full.
      rx_ready = 1'b0;
      ov0 = n_ovr;
      exp_q.push_back(8'h11);
      send_byte(8'h11, 1'b1, BIT);
      send_byte(8'h22, 1'b1, BIT);
      repeat (10) @(posedge CLK100MHZ);
      #1;
      check("overrun_pulses", n_ovr - ov0, 1);
      check("overrun_valid_held", {31'd0, rx_valid}, 32'd1);
      check("overrun_data_held", {24'd0, rx_data}, 32'h11);
      rx_ready = 1'b1;
      @(posedge CLK100MHZ);
      #1;
      rx_ready = 1'b0;
      check("overrun_drained", {31'd0, rx_valid}, 32'd0);

      // Drain 0x00 in exactly the completion cycle of 0xFF.
      exp_q.push_back(8'h00);
      send_byte(8'h00, 1'b1, BIT);
      repeat (10) @(posedge CLK100MHZ);
      #1;
      check("hold_zero_valid", {31'd0, rx_valid}, 32'd1);
      exp_q.push_back(8'hFF);
      ov0 = n_ovr;
      fork
         send_byte(8'hFF, 1'b1, BIT);
         begin
            @(negedge uart_rxd);
            repeat (lat - 1) @(posedge CLK100MHZ);
            #1;
            rx_ready = 1'b1;
            @(posedge CLK100MHZ);
            #1;
            rx_ready = 1'b0;
            check("simul_valid_kept", {31'd0, rx_valid}, 32'd1);
            check("simul_data", {24'd0, rx_data}, 32'hFF);
         end
      join
      repeat (10) @(posedge CLK100MHZ);
      #1;
      check("simul_no_overrun", n_ovr - ov0, 0);
      rx_ready = 1'b1;
      @(posedge CLK100MHZ);
      #1;

      // Reset during data bit 4 of 0x81, released while the line is high.
      v0 = n_valid_cyc;
      fork
         send_byte(8'h81, 1'b1, BIT);
         begin
            repeat (BIT * 5 + BIT / 2) @(posedge CLK100MHZ);
            #1;
            CPU_RESETN = 1'b0;
            #1;
            check("midreset_rx_valid",  {31'd0, rx_valid},  32'd0);
            check("midreset_rx_data",   {24'd0, rx_data},   32'd0);
            check("midreset_frame_err", {31'd0, frame_err}, 32'd0);
            check("midreset_overrun",   {31'd0, overrun},   32'd0);
            check("midreset_rx_busy",   {31'd0, rx_busy},   32'd0);
            repeat (BIT * 3) @(posedge CLK100MHZ);
            #1;
            CPU_RESETN = 1'b1;
         end
      join
      repeat (20) @(posedge CLK100MHZ);
      #1;
      check("midreset_no_valid", n_valid_cyc - v0, 0);
      exp_q.push_back(8'h7E);
      send_byte(8'h7E, 1'b1, BIT);
      repeat (20) @(posedge CLK100MHZ);
      #1;

      check("scoreboard_empty", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
